// File: rtl/gcore_pkg.sv
// gcore_pkg: opcodes, instruction field positions and FSM encoding shared by the issue block.
package gcore_pkg;
  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_LDI = 3'b101,
    OP_SLT = 3'b110,
    OP_BZ  = 3'b111
  } op_e;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WB    = 2'd2
  } state_e;
  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 13;
  localparam int RD_MSB  = 12;
  localparam int RD_LSB  = 11;
  localparam int RS_MSB  = 10;
  localparam int RS_LSB  = 9;
  localparam int RT_MSB  = 1;
  localparam int RT_LSB  = 0;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;
endpackage

// File: rtl/gcore_regfile.sv
// gcore_regfile: 4x8 register file, two read ports, one write port, debug read; R0 is hardwired zero.
module gcore_regfile (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] ra_sel,
  input  logic [1:0] rb_sel,
  input  logic       we,
  input  logic [1:0] w_sel,
  input  logic [7:0] w_data,
  input  logic [1:0] dbg_sel,
  output logic [7:0] ra_data,
  output logic [7:0] rb_data,
  output logic [7:0] dbg_data
);
  logic [7:0] r_q [4];
  // r_q[0] is reset and never written, so plain indexing reads it as zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) r_q[i] <= '0;
    end else if (we && w_sel != 2'd0) begin
      r_q[w_sel] <= w_data;
    end
  end
  assign ra_data  = r_q[ra_sel];
  assign rb_data  = r_q[rb_sel];
  assign dbg_data = r_q[dbg_sel];
endmodule

// File: rtl/alu_issue.sv
// alu_issue: single-issue front end that feeds an external ALU and writes its result back.
module alu_issue
  import gcore_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  output logic        instr_ready,
  output logic [2:0]  alu_op,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  input  logic [7:0]  alu_ans,
  input  logic        alu_zero,
  output logic        res_valid,
  output logic [7:0]  res_data,
  output logic        br_taken,
  output logic [7:0]  br_off,
  input  logic [1:0]  dbg_sel,
  output logic [7:0]  dbg_data
);
  state_e     state_q;
  op_e        op_q;
  logic [1:0] rd_q;
  logic [7:0] imm_q;
  logic [2:0] alu_op_q;
  logic [7:0] alu_a_q;
  logic [7:0] alu_b_q;
  logic [7:0] ra_data;
  logic [7:0] rb_data;
  logic       wb;
  logic       we;
  op_e        op;
  assign op          = op_e'(instr[OP_MSB:OP_LSB]);
  assign instr_ready = state_q == S_IDLE && rst_n;
  assign wb          = state_q == S_WB;
  assign we          = wb && op_q != OP_BZ;
  gcore_regfile u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .ra_sel   (instr[RS_MSB:RS_LSB]),
    .rb_sel   (instr[RT_MSB:RT_LSB]),
    .we       (we),
    .w_sel    (rd_q),
    .w_data   (res_data),
    .dbg_sel  (dbg_sel),
    .ra_data  (ra_data),
    .rb_data  (rb_data),
    .dbg_data (dbg_data)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= OP_ADD;
      rd_q     <= '0;
      imm_q    <= '0;
      alu_op_q <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (instr_valid) begin
          op_q  <= op;
          rd_q  <= instr[RD_MSB:RD_LSB];
          imm_q <= instr[IMM_MSB:IMM_LSB];
          if (op == OP_LDI) begin
            state_q <= S_WB;
          end else begin
            alu_op_q <= op;
            alu_a_q  <= ra_data;
            alu_b_q  <= op == OP_BZ ? 8'h00 : rb_data;
            state_q  <= S_ISSUE;
          end
        end
        S_ISSUE: state_q <= S_WB;
        default: state_q <= S_IDLE;
      endcase
    end
  end
  // alu_ans/alu_zero are only valid during WB, so result and branch are formed from them there
  assign alu_op    = alu_op_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign res_valid = wb;
  assign res_data  = !wb || op_q == OP_BZ ? 8'h00 : op_q == OP_LDI ? imm_q : alu_ans;
  assign br_taken  = wb && op_q == OP_BZ && alu_zero;
  assign br_off    = br_taken ? imm_q : 8'h00;
endmodule
